// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO read port into a registered valid/ready stream
// Ports:
//   clk        clock, all state changes on the rising edge
//   arst_n     asynchronous active-low reset
//   fifo_dout  FIFO read data (combinational head when FWFT=1, registered after rd_en when FWFT=0)
//   fifo_rd_en FIFO pop request
//   fifo_empty FIFO empty flag, FLEV is the level meaning "empty"
//   m_data     output stream data
//   m_valid    output word valid
//   m_ready    consumer accepts the word
//   level      number of words held in the internal buffer
module fifo_stream_reader #(
  parameter int T    = 64,
  parameter bit FWFT = 1'b1,
  parameter bit FLEV = 1'b0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [T-1:0] fifo_dout,
  output logic         fifo_rd_en,
  input  logic         fifo_empty,
  output logic [T-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   level
);
  // registered-output FIFOs need one extra slot for the word still in flight
  localparam int DEPTH = FWFT ? 2 : 3;
  logic [T-1:0] mem [DEPTH];
  logic [1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic pend, cap, xfer, avail;
  assign avail = fifo_empty != FLEV;
  // pops only when every outstanding word is guaranteed a slot; independent of m_ready
  assign fifo_rd_en = arst_n && avail && ({1'b0, level} + {2'b0, pend} < 3'(DEPTH));
  assign cap = FWFT ? fifo_rd_en : pend;
  assign m_valid = level != 2'd0;
  assign xfer = m_valid && m_ready;
  assign rd_nxt = rd_ptr == 2'(DEPTH - 1) ? 2'd0 : rd_ptr + 2'd1;
  assign wr_nxt = wr_ptr == 2'(DEPTH - 1) ? 2'd0 : wr_ptr + 2'd1;
  always_comb begin
    m_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_ptr == 2'(i)) m_data = mem[i];
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      level  <= 2'd0;
      pend   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pend  <= FWFT ? 1'b0 : fifo_rd_en;
      level <= level + {1'b0, cap} - {1'b0, xfer};
      if (cap) wr_ptr <= wr_nxt;
      if (xfer) rd_ptr <= rd_nxt;
      for (int i = 0; i < DEPTH; i++)
        if (cap && wr_ptr == 2'(i)) mem[i] <= fifo_dout;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: checks FWFT/FLEV=0 and registered/FLEV=1 readers against a shared FIFO model
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic m_ready = 1'b0;
  logic [15:0] mem [16384];
  int h0, h1, tl, e0, e1, x0, x1, r0, r1;
  int errors, checks;
  logic hold0, hold1;
  logic [15:0] hd0, hd1, fd0, fd1, d0, d1;
  logic rd0, rd1, v0, v1, fe0, fe1;
  logic [1:0] l0, l1;

  always #5 clk = ~clk;

  // FIFO models: u0 sees a first-word-fall-through port, u1 a registered-output port
  assign fd0 = mem[h0[13:0]];
  assign fe0 = h0 != tl;
  assign fe1 = h1 == tl;
  always @(posedge clk) begin
    if (rd0) h0 <= h0 + 1;
    if (rd1) begin
      fd1 <= mem[h1[13:0]];
      h1 <= h1 + 1;
    end
  end

  fifo_stream_reader #(.T(16), .FWFT(1'b1), .FLEV(1'b0)) u0 (
    .clk(clk), .arst_n(arst_n), .fifo_dout(fd0), .fifo_rd_en(rd0), .fifo_empty(fe0),
    .m_data(d0), .m_valid(v0), .m_ready(m_ready), .level(l0));
  fifo_stream_reader #(.T(16), .FWFT(1'b0), .FLEV(1'b1)) u1 (
    .clk(clk), .arst_n(arst_n), .fifo_dout(fd1), .fifo_rd_en(rd1), .fifo_empty(fe1),
    .m_data(d1), .m_valid(v1), .m_ready(m_ready), .level(l1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[tl[13:0]] = v;
    tl++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int k);
    repeat (k) @(negedge clk);
  endtask

  // scoreboard: output order must equal FIFO pop order; a reset discards everything popped
  always @(negedge clk) begin
    if (!arst_n) begin
      e0 = h0;
      e1 = h1;
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      check("lvl0_max", 32'(l0 <= 2'd2), 32'd1);
      if (hold0) check("hold0", {v0, d0}, {1'b1, hd0});
      if (hold1) check("hold1", {v1, d1}, {1'b1, hd1});
      if (rd0) r0++;
      if (rd1) r1++;
      if (v0 && m_ready) begin
        check("data0", d0, mem[e0[13:0]]);
        e0++;
        x0++;
      end
      if (v1 && m_ready) begin
        check("data1", d1, mem[e1[13:0]]);
        e1++;
        x1++;
      end
      hold0 = v0 && !m_ready;
      hold1 = v1 && !m_ready;
      hd0 = d0;
      hd1 = d1;
    end
  end

  initial begin
    #1 arst_n = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    negs(1);
    check("rst_rd0", rd0, 0);
    check("rst_rd1", rd1, 0);
    check("rst_v0", v0, 0);
    check("rst_v1", v1, 0);
    check("rst_l0", l0, 0);
    check("rst_l1", l1, 0);
    check("rst_d0", d0, 0);
    check("rst_d1", d1, 0);
    // streaming from a preloaded FIFO
    nxt();
    arst_n = 1'b1;
    m_ready = 1'b1;
    negs(1);
    check("a_rd0", rd0, 1);
    check("a_v0", v0, 0);
    check("a_rd1", rd1, 1);
    check("a_v1", v1, 0);
    negs(1);
    check("a_v0_lat", v0, 1);
    check("a_d0_first", d0, 16'h01);
    check("a_l0_steady", l0, 1);
    check("a_v1_early", v1, 0);
    negs(1);
    check("a_v1_lat", v1, 1);
    check("a_d1_first", d1, 16'h01);
    check("a_l1_steady", l1, 1);
    check("a_d0_2", d0, 16'h02);
    negs(2);
    check("a_d0_4", d0, 16'h04);
    check("a_d1_3", d1, 16'h03);
    negs(5);
    check("a_x0", x0, 8);
    check("a_l0_end", l0, 0);
    check("a_rd0_end", rd0, 0);
    check("a_v0_end", v0, 0);
    negs(1);
    check("a_x1", x1, 8);
    check("a_l1_end", l1, 0);
    check("a_rd1_end", rd1, 0);
    // backpressure
    nxt();
    r0 = 0;
    r1 = 0;
    x0 = 0;
    x1 = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h11 + 16'(i));
    negs(6);
    check("b_pops1", r1, 3);
    check("b_pops0", r0, 2);
    check("b_l1_full", l1, 3);
    check("b_l0_full", l0, 2);
    check("b_rd1_off", rd1, 0);
    check("b_rd0_off", rd0, 0);
    check("b_d0_head", {v0, d0}, {1'b1, 16'h11});
    check("b_d1_head", {v1, d1}, {1'b1, 16'h11});
    nxt();
    m_ready = 1'b1;
    negs(1);
    check("b_rd1_no_ready_path", rd1, 0);
    check("b_rd0_no_ready_path", rd0, 0);
    nxt();
    m_ready = 1'b0;
    negs(1);
    check("b_rd1_reassert", rd1, 1);
    check("b_rd0_reassert", rd0, 1);
    negs(3);
    check("b_pops1_after", r1, 4);
    check("b_pops0_after", r0, 3);
    check("b_l1_refull", l1, 3);
    check("b_l0_refull", l0, 2);
    check("b_d0_next", d0, 16'h12);
    check("b_d1_next", d1, 16'h12);
    nxt();
    m_ready = 1'b1;
    for (int i = 0; i < 60 && (x0 < 8 || x1 < 8); i++) negs(1);
    check("b_x0", x0, 8);
    check("b_x1", x1, 8);
    repeat (3) nxt();
    negs(1);
    check("b_l0_drained", l0, 0);
    check("b_l1_drained", l1, 0);
    // FIFO runs empty, then refills five cycles later
    nxt();
    push(16'h41);
    negs(1);
    check("c_rd0", rd0, 1);
    check("c_rd1", rd1, 1);
    negs(1);
    check("c_d0", {v0, d0}, {1'b1, 16'h41});
    for (int i = 0; i < 4; i++) begin
      check("c_rd0_idle", rd0, 0);
      check("c_rd1_idle", rd1, 0);
      if (i < 3) negs(1);
    end
    nxt();
    push(16'h42);
    negs(1);
    check("c_rd0_refill", rd0, 1);
    check("c_rd1_refill", rd1, 1);
    negs(1);
    check("c_d0_refill", {v0, d0}, {1'b1, 16'h42});
    check("c_v1_refill_early", v1, 0);
    negs(1);
    check("c_d1_refill", {v1, d1}, {1'b1, 16'h42});
    repeat (3) nxt();
    // reset with words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'h31 + 16'(i));
    negs(6);
    check("d_l0_pre", l0, 2);
    check("d_l1_pre", l1, 3);
    nxt();
    arst_n = 1'b0;
    #1;
    check("d_v0_async", v0, 0);
    check("d_v1_async", v1, 0);
    check("d_rd0_async", rd0, 0);
    check("d_rd1_async", rd1, 0);
    check("d_l0_async", l0, 0);
    check("d_l1_async", l1, 0);
    negs(1);
    nxt();
    arst_n = 1'b1;
    m_ready = 1'b1;
    x0 = 0;
    x1 = 0;
    negs(1);
    check("d_rd0_release", rd0, 1);
    negs(1);
    check("d_d0_head", {v0, d0}, {1'b1, 16'h33});
    negs(1);
    check("d_d1_head", {v1, d1}, {1'b1, 16'h34});
    for (int i = 0; i < 40 && (x0 < 4 || x1 < 3); i++) negs(1);
    check("d_x0", x0, 4);
    check("d_x1", x1, 3);
    // random fill and random backpressure
    nxt();
    x0 = 0;
    x1 = 0;
    for (int c = 0, n = 0; c < 40000 && n < 10000; c++) begin
      m_ready = 1'($urandom % 2);
      if ($urandom % 4 != 0) begin
        push(16'($urandom));
        n++;
      end
      nxt();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20000 && (x0 < 10000 || x1 < 10000); i++) negs(1);
    check("e_x0", x0, 10000);
    check("e_x1", x1, 10000);
    repeat (4) nxt();
    negs(1);
    check("e_l0_end", l0, 0);
    check("e_l1_end", l1, 0);
    check("e_rd0_end", rd0, 0);
    check("e_rd1_end", rd1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

- Read-side drain engine for the synchronous FIFO.
- Pops words from the FIFO read port (`dout`/`rd_en`/`empty`, either FWFT or registered-output mode) and presents them as a valid/ready output stream with registered outputs.
- Sustains one word per cycle under continuous `m_ready`.
- Sits between a FIFO instance and any `sc_stream_out`-style consumer.

## Interface
Parameters:
- `T`, 64: data width; must equal the FIFO's `T`.
- `FWFT`, 1: matches the FIFO's `FWFT`. 1 means `fifo_dout` shows the head combinationally. 0 means `fifo_dout` is valid the cycle after `fifo_rd_en`.
- `FLEV`, 0: level of `fifo_empty` that means "FIFO is empty"; matches the FIFO's `FLEV`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `fifo_dout`  in  T  FIFO read data.
- `fifo_rd_en`  out  1  FIFO pop request.
- `fifo_empty`  in  1  FIFO empty flag, polarity per `FLEV`.
- `m_data`  out  T  output stream data.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `level`  out  2  number of words held in the internal buffer (0..DEPTH).

## Operation
- Internal buffer:
  - FIFO of DEPTH registers, DEPTH = 2 when FWFT=1 and 3 when FWFT=0.
  - 2-bit read and write pointers wrap modulo DEPTH.
  - `level` is the occupancy register.
- `avail` = (`fifo_empty` != FLEV).
- `pend` (FWFT=0 only):
  - 1-bit register, set to `fifo_rd_en` each cycle; it marks a word in flight.
  - Tied to 0 when FWFT=1.
- Pop rule: `fifo_rd_en` = `arst_n` && `avail` && (`level` + `pend` < DEPTH).
  - Combinational only from registered state and `fifo_empty`.
  - There is no path from `m_ready` to `fifo_rd_en`.
- Capture:
  - FWFT=1: on an edge where `fifo_rd_en`=1, write `fifo_dout` into the buffer.
  - FWFT=0: on an edge where `pend`=1, write `fifo_dout` into the buffer.
- Output:
  - `m_valid` = (`level` != 0).
  - `m_data` = buffer[rd_ptr], driven from registers.
  - A transfer occurs on an edge with `m_valid` && `m_ready`; rd_ptr advances.
- Simultaneous capture and transfer: `level` unchanged, both pointers advance, order preserved.
- `level` never exceeds DEPTH and is never decremented below 0. The pop rule guarantees room for every in-flight word, so no capture is ever dropped.
- Stream rules:
  - Once `m_valid`=1, `m_valid` and `m_data` hold until the transfer.
  - `m_valid` never depends on `m_ready`.
- Words exit in exact FIFO pop order. No duplication or loss.

## Timing
- Reset (`arst_n`=0), effective immediately without a clock:
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `level`=0.
  - `pend`=0, pointers=0, buffer contents 0.
- Release: first pop may occur in the first cycle with `arst_n`=1 and `avail`=1.
- Latency, FIFO non-empty to `m_valid`, with an empty buffer:
  - FWFT=1: `fifo_rd_en` in cycle n; `m_valid`=1 in cycle n+1.
  - FWFT=0: `fifo_rd_en` in cycle n; data captured at the end of n+1; `m_valid`=1 in cycle n+2.
- Throughput: one word per cycle in both modes with `m_ready` held high and the FIFO non-empty.
  - FWFT=1 steady state: `level`=1.
  - FWFT=0 steady state: `level`=1, `pend`=1.
- Backpressure:
  - With `m_ready`=0, pops continue until `level` + `pend` = DEPTH, then `fifo_rd_en`=0.
  - In-flight words (FWFT=0) still land.
  - When `m_ready` returns, `fifo_rd_en` reasserts the cycle after `level` drops.
- FIFO runs empty mid-stream: `fifo_rd_en` drops the same cycle `avail`=0; buffered words continue to drain.
- Reset mid-operation: the in-flight word (`pend`) and all buffered words are discarded. The FIFO's own reset is independent; the bench resets both together.
- Pointer wrap: DEPTH=3 wraps 2→0 and never uses value 3. DEPTH=2 wraps 1→0.

## Test plan
- Reset: assert `arst_n`=0 mid-stream with `level`=2.
  - Immediately `m_valid`=0, `fifo_rd_en`=0, `level`=0.
  - After release, the next word out is the FIFO's current head. No stale words appear.
- Streaming, FWFT=1: FIFO preloaded with 0x01..0x08, `m_ready`=1.
  - `m_valid` rises 1 cycle after the first pop.
  - 0x01..0x08 transfer on 8 consecutive edges.
  - `level`=0 and `fifo_rd_en`=0 afterward.
- Streaming, FWFT=0, same data:
  - `m_valid` rises 2 cycles after the first pop.
  - 8 back-to-back transfers in order.
- Backpressure, FWFT=0: `m_ready`=0 with 8 words queued.
  - `fifo_rd_en` pulses exactly 3 times, then `level`=3.
  - Release `m_ready` for 1 cycle: 0x01 transfers and exactly one new pop follows.
  - All 8 words eventually arrive in order.
- Random `m_ready` (50%) and random FIFO fills, 10k words, both FWFT settings, FLEV ∈ {0,1}:
  - Scoreboard matches exactly.
  - `m_data` is stable while `m_valid` && !`m_ready`.
  - `level` ≤ DEPTH always.
- FIFO underflow edge: FIFO goes empty with `level`=1, refills 5 cycles later.
  - `fifo_rd_en`=0 throughout the empty period.
  - No bubble beyond the stated latency.
